// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, instruction ROM address, IF/ID
// pipeline register, start/stall/redirect handling, and halt detection with
// a fixed-length drain before reporting halted.

package fetch_unit_pkg;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // Opcode field width; the opcode is the top OP_W bits of an instruction.
   localparam int OP_W = 5;

endpackage : fetch_unit_pkg


module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W         = 8,
   parameter int              INSTR_W      = 9,
   parameter logic [OP_W-1:0] HALT_OP      = 5'b11010,
   parameter int              DRAIN_CYCLES = 3,
   parameter int              CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [PC_W-1:0]    start_addr,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   fetch_count
);

   // Drain counter only needs to hold DRAIN_CYCLES down to 1.
   localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_t               state;
   state_t               state_next;
   logic [PC_W-1:0]      pc;
   logic [DRAIN_W-1:0]   drain_cnt;

   // Decoded per-cycle actions; at most one of start_go / redir_go /
   // issue / drain_step is set in any cycle.
   logic                 is_halt;
   logic                 start_go;
   logic                 redir_go;
   logic                 issue;
   logic                 halt_go;
   logic                 drain_step;
   logic                 drain_last;

   // The ROM reads combinationally, so its address is simply the PC.
   assign imem_addr = pc;

   // Halt opcode sits in the top bits of the word coming back from the ROM.
   assign is_halt = (imem_data[INSTR_W-1 -: OP_W] == HALT_OP);

   // The drain ends on the step that takes the counter from 1 to 0.
   assign drain_last = (drain_cnt == DRAIN_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection; redirect outranks stall, and stall freezes the drain.
   always_comb begin
      // NOTE: the default assignment up front keeps every path covered, so
      // no latch is inferred for state_next.
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!redirect && !stall && is_halt) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (redirect) begin
               state_next = ST_RUN;
            end else if (!stall && drain_last) begin
               state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (start) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Per-state action decode plus the status outputs derived from state.
   always_comb begin
      start_go   = 1'b0;
      redir_go   = 1'b0;
      issue      = 1'b0;
      halt_go    = 1'b0;
      drain_step = 1'b0;
      busy       = (state == ST_RUN) || (state == ST_DRAIN);
      halted     = (state == ST_HALTED);
      case (state)
         ST_IDLE: begin
            start_go = start;
         end
         ST_RUN: begin
            redir_go = redirect;
            issue    = !redirect && !stall;
            halt_go  = !redirect && !stall && is_halt;
         end
         ST_DRAIN: begin
            redir_go   = redirect;
            drain_step = !redirect && !stall;
         end
         ST_HALTED: begin
            start_go = start;
         end
         default: begin
            start_go = 1'b0;
         end
      endcase
   end

   // Program counter: load on start/redirect, advance on issue except on halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (start_go) begin
         pc <= start_addr;
      end else if (redir_go) begin
         pc <= redirect_pc;
      end else if (issue && !halt_go) begin
         pc <= pc + 1'b1;
      end
   end

   // IF/ID register: capture on issue, turn into a bubble on flush or drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (issue) begin
         instr_out   <= imem_data;
         instr_pc    <= pc;
         instr_valid <= 1'b1;
      end else if (redir_go || drain_step) begin
         instr_valid <= 1'b0;
      end
   end

   // Issued-instruction counter: cleared on start, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (start_go) begin
         fetch_count <= '0;
      end else if (issue && (fetch_count != {CNT_W{1'b1}})) begin
         fetch_count <= fetch_count + 1'b1;
      end
   end

   // Drain counter: armed when the halt issues, counts down on unstalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
      end else if (halt_go) begin
         drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
      end else if (redir_go) begin
         drain_cnt <= '0;
      end else if (drain_step) begin
         drain_cnt <= drain_cnt - 1'b1;
      end
   end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand-written multi-cycle
// sequences (halt/drain, redirect during drain, wrap, async reset) and a
// randomized run checked against a behavioural model.

module tb_fetch_unit;

   localparam int HALT_OPC = 26;  // 5'b11010

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_addr = '0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [7:0]  redirect_pc = '0;

   logic [7:0]  imem_addr,   imem_addr_s;
   logic [8:0]  imem_data,   imem_data_s;
   logic [8:0]  instr_out,   instr_out_s;
   logic [7:0]  instr_pc,    instr_pc_s;
   logic        instr_valid, instr_valid_s;
   logic        busy,        busy_s;
   logic        halted,      halted_s;
   logic [15:0] fetch_count;
   logic [2:0]  fetch_count_s;

   logic [8:0]  rom [256];

   assign imem_data   = rom[imem_addr];
   assign imem_data_s = rom[imem_addr_s];

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .busy        (busy),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   fetch_unit #(.CNT_W(3)) dut_small (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_addr  (start_addr),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr_s),
      .imem_data   (imem_data_s),
      .instr_out   (instr_out_s),
      .instr_pc    (instr_pc_s),
      .instr_valid (instr_valid_s),
      .busy        (busy_s),
      .halted      (halted_s),
      .fetch_count (fetch_count_s)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      int pc;
      int ipc;
      int instr;
      int valid;
      int busy;
      int halted;
      int cnt;
   } exp_t;

   typedef struct {
      logic       start;
      logic [7:0] sa;
      logic       stall;
      logic       redirect;
      logic [7:0] rpc;
      exp_t       e;
   } vec_t;

   function automatic exp_t mk(input int pc, input int ipc, input int instr,
                               input int valid, input int bsy, input int hlt,
                               input int cnt);
      exp_t e;
      e.pc = pc; e.ipc = ipc; e.instr = instr; e.valid = valid;
      e.busy = bsy; e.halted = hlt; e.cnt = cnt;
      return e;
   endfunction

   function automatic vec_t v(input logic st, input logic [7:0] sa, input logic sl,
                              input logic rd, input logic [7:0] rp, input exp_t e);
      vec_t r;
      r.start = st; r.sa = sa; r.stall = sl; r.redirect = rd; r.rpc = rp; r.e = e;
      return r;
   endfunction

   // Default ROM contents: a scrambled pattern with every halt opcode removed.
   function automatic int rom_word(input int a);
      int w;
      w = (a * 37 + 11) & 'h1FF;
      if (((w >> 4) & 31) == HALT_OPC) w = w & 'hFF;
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, " imem_addr"},   32'(imem_addr),   e.pc);
      check({tag, " instr_out"},   32'(instr_out),   e.instr);
      check({tag, " instr_pc"},    32'(instr_pc),    e.ipc);
      check({tag, " instr_valid"}, 32'(instr_valid), e.valid);
      check({tag, " busy"},        32'(busy),        e.busy);
      check({tag, " halted"},      32'(halted),      e.halted);
      check({tag, " fetch_count"}, 32'(fetch_count), e.cnt);
      check({tag, " small_count"}, 32'(fetch_count_s), (e.cnt > 7) ? 7 : e.cnt);
      check({tag, " small_rest"},
            {4'b0, imem_addr_s, instr_out_s, instr_pc_s, instr_valid_s, busy_s, halted_s},
            {4'b0, 8'(e.pc), 9'(e.instr), 8'(e.ipc), 1'(e.valid), 1'(e.busy), 1'(e.halted)});
   endtask

   task automatic drive(input logic st, input logic [7:0] sa, input logic sl,
                        input logic rd, input logic [7:0] rp);
      start = st; start_addr = sa; stall = sl; redirect = rd; redirect_pc = rp;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: "active" covers fetching and draining, drain
   // holds the number of bubbles still owed (0 when not draining).
   int m_pc, m_ipc, m_iout, m_valid, m_cnt, m_drain, m_active, m_halted;

   task automatic model_reset();
      m_pc = 0; m_ipc = 0; m_iout = 0; m_valid = 0; m_cnt = 0;
      m_drain = 0; m_active = 0; m_halted = 0;
   endtask

   task automatic model_step(input logic st, input logic [7:0] sa, input logic sl,
                             input logic rd, input logic [7:0] rp);
      int w;
      if (m_active == 0) begin
         if (st) begin
            m_pc = int'(sa); m_cnt = 0; m_halted = 0; m_active = 1; m_drain = 0;
         end
      end else if (rd) begin
         m_pc = int'(rp); m_valid = 0; m_drain = 0;
      end else if (sl) begin
         m_drain = m_drain;
      end else if (m_drain > 0) begin
         m_valid = 0;
         m_drain = m_drain - 1;
         if (m_drain == 0) begin
            m_active = 0; m_halted = 1;
         end
      end else begin
         w = int'(rom[m_pc]);
         m_iout = w; m_ipc = m_pc; m_valid = 1;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (((w >> 4) & 31) == HALT_OPC) m_drain = 3;
         else m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   vec_t tbl [10];

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 9'(rom_word(i));

      tbl[0] = v(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, mk('h10, 'h00, 0, 0, 1, 0, 0));
      tbl[1] = v(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, mk('h11, 'h10, rom_word('h10), 1, 1, 0, 1));
      tbl[2] = v(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, mk('h12, 'h11, rom_word('h11), 1, 1, 0, 2));
      tbl[3] = v(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, mk('h13, 'h12, rom_word('h12), 1, 1, 0, 3));
      tbl[4] = v(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, mk('h13, 'h12, rom_word('h12), 1, 1, 0, 3));
      tbl[5] = v(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, mk('h13, 'h12, rom_word('h12), 1, 1, 0, 3));
      tbl[6] = v(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, mk('h14, 'h13, rom_word('h13), 1, 1, 0, 4));
      tbl[7] = v(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, mk('h40, 'h13, rom_word('h13), 0, 1, 0, 4));
      tbl[8] = v(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, mk('h41, 'h40, rom_word('h40), 1, 1, 0, 5));
      tbl[9] = v(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, mk('h42, 'h41, rom_word('h41), 1, 1, 0, 6));

      // Reset state.
      do_reset();
      check_all("reset", mk(0, 0, 0, 0, 0, 0, 0));

      // Directed table: sequential fetch, stall hold, redirect over stall, start ignored.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].start, tbl[i].sa, tbl[i].stall, tbl[i].redirect, tbl[i].rpc);
         step();
         check_all($sformatf("vec%0d", i), tbl[i].e);
      end

      // Halt at 0x05: issue, three bubbles, halted on the third, then restart.
      do_reset();
      rom[8'h05] = 9'h1A0;
      rom[8'h30] = 9'h1A5;
      drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      step();
      check_all("halt_start", mk(0, 0, 0, 0, 1, 0, 0));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 5; k++) begin
         step();
         check_all($sformatf("halt_pre%0d", k), mk(k + 1, k, rom_word(k), 1, 1, 0, k + 1));
      end
      step();
      check_all("halt_issue", mk(5, 5, 'h1A0, 1, 1, 0, 6));
      for (int d = 1; d <= 3; d++) begin
         step();
         check_all($sformatf("drain%0d", d),
                   mk(5, 5, 'h1A0, 0, (d < 3) ? 1 : 0, (d == 3) ? 1 : 0, 6));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
      step();
      check_all("halted_ignore", mk(5, 5, 'h1A0, 0, 0, 1, 6));
      drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      step();
      check_all("restart", mk(0, 5, 'h1A0, 0, 1, 0, 0));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step();
      check_all("restart_fetch", mk(1, 0, rom_word(0), 1, 1, 0, 1));

      // Halt at 0x30 on a wrong path: redirect in the second drain cycle.
      drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h30);
      step();
      check_all("to_30", mk('h30, 0, rom_word(0), 0, 1, 0, 1));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step();
      check_all("halt30_issue", mk('h30, 'h30, 'h1A5, 1, 1, 0, 2));
      step();
      check_all("halt30_drain1", mk('h30, 'h30, 'h1A5, 0, 1, 0, 2));
      drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h20);
      step();
      check_all("drain_redirect", mk('h20, 'h30, 'h1A5, 0, 1, 0, 2));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         step();
         check_all($sformatf("after_redir%0d", k),
                   mk('h21 + k, 'h20 + k, rom_word('h20 + k), 1, 1, 0, 3 + k));
      end

      // PC wrap from 0xFF to 0x00.
      do_reset();
      drive(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00);
      step();
      check_all("wrap_start", mk('hFE, 0, 0, 0, 1, 0, 0));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step();
      check_all("wrap_fe", mk('hFF, 'hFE, rom_word('hFE), 1, 1, 0, 1));
      step();
      check_all("wrap_ff", mk(0, 'hFF, rom_word('hFF), 1, 1, 0, 2));
      step();
      check_all("wrap_00", mk(1, 0, rom_word(0), 1, 1, 0, 3));

      // Asynchronous reset mid-RUN, between clock edges.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", mk(0, 0, 0, 0, 0, 0, 0));
      step();
      check_all("rst_held", mk(0, 0, 0, 0, 0, 0, 0));
      #2;
      rst_n = 1'b1;
      step();
      check_all("idle_after_rst", mk(0, 0, 0, 0, 0, 0, 0));

      // Randomized run against the behavioural model.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 11) == 0) rom[i] = {5'b11010, 4'($urandom)};
         else rom[i] = 9'(rom_word(int'($urandom & 'hFF)));
      end
      for (int i = 0; i < 3000; i++) begin
         logic       st, sl, rd;
         logic [7:0] sa, rp;
         st = ($urandom_range(0, 7) == 0);
         sl = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 7) == 0);
         sa = 8'($urandom);
         rp = 8'($urandom);
         drive(st, sa, sl, rd, rp);
         step();
         model_step(st, sa, sl, rd, rp);
         check_all($sformatf("rand%0d", i),
                   mk(m_pc, m_ipc, m_iout, m_valid, m_active, m_halted, m_cnt));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_fetch_unit
